mccpu_ctrl: RTL and testbench

Multi-cycle control unit for the MCCPU datapath. It decodes the instruction register's opcode and funct fields and sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath enable and mux select, including the register-file write enable, the destination-select and the write-data-select that feed the register file. It also maintains an instruction-retired counter and a sticky illegal-instruction flag for debug.

---
 rtl/mccpu_ctrl_pkg.sv | 84 ++++++++
 rtl/alu_dec.sv | 39 +++
 rtl/mccpu_ctrl.sv | 139 +++++++++++++
 tb/tb_mccpu_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mccpu_ctrl_pkg.sv
// rtl/mccpu_ctrl_pkg.sv - shared opcode, funct, state and select encodings for the MCCPU
package mccpu_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SLT = 4'd4;
   localparam logic [3:0] ALU_LUI = 4'd5;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_JR     = 2'b11;

   localparam logic [1:0] REGDST_RT  = 2'b00;
   localparam logic [1:0] REGDST_RD  = 2'b01;
   localparam logic [1:0] REGDST_R31 = 2'b10;

   localparam logic [1:0] WDSEL_ALU = 2'b00;
   localparam logic [1:0] WDSEL_MEM = 2'b01;
   localparam logic [1:0] WDSEL_PC  = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_IMM2 = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_FETCH   = 4'd1,
      S_DECODE  = 4'd2,
      S_EXE_R   = 4'd3,
      S_EXE_I   = 4'd4,
      S_MEM_ADR = 4'd5,
      S_MEM_RD  = 4'd6,
      S_MEM_WB  = 4'd7,
      S_MEM_WR  = 4'd8,
      S_ALU_WB  = 4'd9,
      S_BRANCH  = 4'd10,
      S_JUMP    = 4'd11,
      S_JR      = 4'd12
   } state_t;

   // S_FETCH doubles as the "unsupported instruction" verdict: no legal decode lands there.
   function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] funct);
      state_t t;
      t = S_FETCH;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: t = S_EXE_R;
               FN_JR:                                 t = S_JR;
               default:                               t = S_FETCH;
            endcase
         end
         OP_LW, OP_SW:             t = S_MEM_ADR;
         OP_ADDI, OP_ORI, OP_LUI:  t = S_EXE_I;
         OP_BEQ, OP_BNE:           t = S_BRANCH;
         OP_J, OP_JAL:             t = S_JUMP;
         default:                  t = S_FETCH;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - combinational ALU operation and immediate-extension decoder
module alu_dec
   import mccpu_ctrl_pkg::*;
(
   input  state_t      state,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   output logic [3:0]  alu_op,
   output logic        ext_op
);

   always_comb begin
      alu_op = ALU_ADD;
      ext_op = 1'b0;
      case (state)
         S_DECODE, S_MEM_ADR: ext_op = 1'b1;
         S_EXE_R: begin
            case (funct)
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               default: alu_op = ALU_ADD;
            endcase
         end
         S_EXE_I: begin
            // only addi, ori and lui reach EXE_I, so the default arm is addi
            case (op)
               OP_ORI:  alu_op = ALU_OR;
               OP_LUI:  alu_op = ALU_LUI;
               default: ext_op = 1'b1;
            endcase
         end
         S_BRANCH: alu_op = ALU_SUB;
         default:  alu_op = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mccpu_ctrl.sv
// rtl/mccpu_ctrl.sv - multi-cycle MCCPU control FSM with retired-instruction counter and illegal flag
module mccpu_ctrl
   import mccpu_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic        PCWr,
   output logic [1:0]  PCSrc,
   output logic        IRWr,
   output logic        IorD,
   output logic        MemWr,
   output logic        RFWr,
   output logic [1:0]  RegDst,
   output logic [1:0]  WDSel,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic        EXTOp,
   output logic [3:0]  ALUOp,
   output logic        illegal,
   output logic [31:0] instret,
   output logic [3:0]  state
);

   state_t cur, nxt;
   logic   retire;
   logic   dec_illegal;

   assign state       = cur;
   assign retire      = cur inside {S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JR};
   assign dec_illegal = (cur == S_DECODE) && (decode_target(op, funct) == S_FETCH);

   alu_dec u_alu_dec (
      .state  (cur),
      .op     (op),
      .funct  (funct),
      .alu_op (ALUOp),
      .ext_op (EXTOp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur     <= S_IDLE;
         instret <= '0;
         illegal <= 1'b0;
      end else begin
         cur <= nxt;
         if (retire)
            instret <= instret + 32'd1;
         if (dec_illegal)
            illegal <= 1'b1;
      end
   end

   always_comb begin
      nxt     = S_FETCH;
      PCWr    = 1'b0;
      PCSrc   = PCSRC_ALU;
      IRWr    = 1'b0;
      IorD    = 1'b0;
      MemWr   = 1'b0;
      RFWr    = 1'b0;
      RegDst  = REGDST_RT;
      WDSel   = WDSEL_ALU;
      ALUSrcA = 1'b0;
      ALUSrcB = SRCB_REG;
      case (cur)
         S_IDLE: nxt = S_FETCH;
         S_FETCH: begin
            IRWr    = 1'b1;
            PCWr    = 1'b1;
            PCSrc   = PCSRC_ALU;
            ALUSrcB = SRCB_FOUR;
            nxt     = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM2;
            nxt     = decode_target(op, funct);
         end
         S_EXE_R: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_REG;
            nxt     = S_ALU_WB;
         end
         S_EXE_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            nxt     = S_ALU_WB;
         end
         S_ALU_WB: begin
            RFWr   = 1'b1;
            WDSel  = WDSEL_ALU;
            RegDst = (op == OP_RTYPE) ? REGDST_RD : REGDST_RT;
         end
         S_MEM_ADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            nxt     = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            IorD = 1'b1;
            nxt  = S_MEM_WB;
         end
         S_MEM_WB: begin
            RFWr   = 1'b1;
            WDSel  = WDSEL_MEM;
            RegDst = REGDST_RT;
         end
         S_MEM_WR: begin
            IorD  = 1'b1;
            MemWr = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_REG;
            PCSrc   = PCSRC_ALUOUT;
            PCWr    = (op == OP_BEQ) ? zero : !zero;
         end
         S_JUMP: begin
            PCWr  = 1'b1;
            PCSrc = PCSRC_JUMP;
            // PC already holds PC+4 here, so jal links straight from PC
            if (op == OP_JAL) begin
               RFWr   = 1'b1;
               RegDst = REGDST_R31;
               WDSel  = WDSEL_PC;
            end
         end
         S_JR: begin
            PCWr  = 1'b1;
            PCSrc = PCSRC_JR;
         end
         default: nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mccpu_ctrl.sv
// tb/tb_mccpu_ctrl.sv - scoreboard testbench for the MCCPU control unit
module tb_mccpu_ctrl;
   import mccpu_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [5:0]  op = 6'h00;
   logic [5:0]  funct = 6'h00;
   logic        zero = 1'b0;
   logic        PCWr, IRWr, IorD, MemWr, RFWr, ALUSrcA, EXTOp, illegal;
   logic [1:0]  PCSrc, RegDst, WDSel, ALUSrcB;
   logic [3:0]  ALUOp, state;
   logic [31:0] instret;

   mccpu_ctrl dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
      .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .IorD(IorD), .MemWr(MemWr),
      .RFWr(RFWr), .RegDst(RegDst), .WDSel(WDSel), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .EXTOp(EXTOp), .ALUOp(ALUOp), .illegal(illegal),
      .instret(instret), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] st;
      logic       pcwr;
      logic [1:0] pcsrc;
      logic       irwr;
      logic       iord;
      logic       memwr;
      logic       rfwr;
      logic [1:0] regdst;
      logic [1:0] wdsel;
      logic       srca;
      logic [1:0] srcb;
      logic       ext;
      logic [3:0] aluop;
   } rec_t;

   rec_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_instret = '0;
   logic        exp_illegal = 1'b0;

   function automatic rec_t blank(input logic [3:0] st);
      rec_t r;
      r = '0;
      r.st = st;
      return r;
   endfunction

   function automatic rec_t observed();
      rec_t r;
      r.st = state;     r.pcwr = PCWr;     r.pcsrc = PCSrc;   r.irwr = IRWr;
      r.iord = IorD;    r.memwr = MemWr;   r.rfwr = RFWr;     r.regdst = RegDst;
      r.wdsel = WDSel;  r.srca = ALUSrcA;  r.srcb = ALUSrcB;  r.ext = EXTOp;
      r.aluop = ALUOp;
      return r;
   endfunction

   task automatic push_expect(input logic [5:0] o, input logic [5:0] f, input logic z);
      rec_t r;
      logic retires;
      retires = 1'b1;
      r = blank(S_FETCH); r.pcwr = 1; r.irwr = 1; r.srcb = 2'b01; q.push_back(r);
      r = blank(S_DECODE); r.srcb = 2'b11; r.ext = 1; q.push_back(r);
      case (o)
         OP_RTYPE: begin
            if (f == FN_JR) begin
               r = blank(S_JR); r.pcwr = 1; r.pcsrc = 2'b11; q.push_back(r);
            end else if (f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
               r = blank(S_EXE_R); r.srca = 1;
               r.aluop = (f == FN_SUB) ? ALU_SUB : (f == FN_AND) ? ALU_AND :
                         (f == FN_OR)  ? ALU_OR  : (f == FN_SLT) ? ALU_SLT : ALU_ADD;
               q.push_back(r);
               r = blank(S_ALU_WB); r.rfwr = 1; r.regdst = 2'b01; q.push_back(r);
            end else begin
               retires = 1'b0;
            end
         end
         OP_ADDI, OP_ORI, OP_LUI: begin
            r = blank(S_EXE_I); r.srca = 1; r.srcb = 2'b10; r.ext = (o == OP_ADDI);
            r.aluop = (o == OP_ORI) ? ALU_OR : (o == OP_LUI) ? ALU_LUI : ALU_ADD;
            q.push_back(r);
            r = blank(S_ALU_WB); r.rfwr = 1; q.push_back(r);
         end
         OP_LW, OP_SW: begin
            r = blank(S_MEM_ADR); r.srca = 1; r.srcb = 2'b10; r.ext = 1; q.push_back(r);
            if (o == OP_LW) begin
               r = blank(S_MEM_RD); r.iord = 1; q.push_back(r);
               r = blank(S_MEM_WB); r.rfwr = 1; r.wdsel = 2'b01; q.push_back(r);
            end else begin
               r = blank(S_MEM_WR); r.iord = 1; r.memwr = 1; q.push_back(r);
            end
         end
         OP_BEQ, OP_BNE: begin
            r = blank(S_BRANCH); r.srca = 1; r.aluop = ALU_SUB; r.pcsrc = 2'b01;
            r.pcwr = (o == OP_BEQ) ? z : !z;
            q.push_back(r);
         end
         OP_J, OP_JAL: begin
            r = blank(S_JUMP); r.pcwr = 1; r.pcsrc = 2'b10;
            if (o == OP_JAL) begin
               r.rfwr = 1; r.regdst = 2'b10; r.wdsel = 2'b10;
            end
            q.push_back(r);
         end
         default: retires = 1'b0;
      endcase
      if (retires) exp_instret = exp_instret + 32'd1;
      else         exp_illegal = 1'b1;
   endtask

   // Enters FETCH, checks the counters left by the previous instruction, then drains the scoreboard.
   task automatic exec(input string name, input logic [5:0] o, input logic [5:0] f, input logic z);
      rec_t e, g;
      @(posedge clk); #1;
      checks++;
      if (instret !== exp_instret) begin
         errors++; $display("FAIL %s instret_before got %0d exp %0d", name, instret, exp_instret);
      end
      checks++;
      if (illegal !== exp_illegal) begin
         errors++; $display("FAIL %s illegal_before got %0b exp %0b", name, illegal, exp_illegal);
      end
      op = o; funct = f; zero = z;
      push_expect(o, f, z);
      for (int i = 1; q.size() > 0 && i <= 8; i++) begin
         @(negedge clk);
         e = q.pop_front();
         g = observed();
         checks++;
         if (g !== e) begin
            errors++; $display("FAIL %s cycle%0d got %h exp %h", name, i, g, e);
         end
      end
   endtask

   task automatic test_reset();
      rec_t g;
      #1 rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         g = observed();
         checks++;
         if (g !== blank(S_IDLE)) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", g, blank(S_IDLE));
         end
         checks++;
         if (instret !== 32'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_counters got %0d/%0b exp 0/0", instret, illegal);
         end
      end
      rst_n = 1'b1;
      #1;
      g = observed();
      checks++;
      if (g !== blank(S_IDLE)) begin
         errors++; $display("FAIL reset_release got %h exp %h", g, blank(S_IDLE));
      end
   endtask

   task automatic test_rtype();
      exec("add", OP_RTYPE, FN_ADD, 1'b0);
      exec("sub", OP_RTYPE, FN_SUB, 1'b0);
      exec("and", OP_RTYPE, FN_AND, 1'b0);
      exec("or",  OP_RTYPE, FN_OR,  1'b0);
      exec("slt", OP_RTYPE, FN_SLT, 1'b0);
   endtask

   task automatic test_itype();
      exec("addi", OP_ADDI, 6'h15, 1'b0);
      exec("ori",  OP_ORI,  6'h3F, 1'b0);
      exec("lui",  OP_LUI,  6'h00, 1'b0);
   endtask

   task automatic test_mem();
      exec("lw", OP_LW, 6'h04, 1'b0);
      exec("sw", OP_SW, 6'h08, 1'b0);
   endtask

   task automatic test_branch();
      exec("beq_z1", OP_BEQ, 6'h00, 1'b1);
      exec("beq_z0", OP_BEQ, 6'h00, 1'b0);
      exec("bne_z0", OP_BNE, 6'h00, 1'b0);
      exec("bne_z1", OP_BNE, 6'h00, 1'b1);
   endtask

   task automatic test_jump();
      exec("j",   OP_J,     6'h11, 1'b0);
      exec("jal", OP_JAL,   6'h22, 1'b0);
      exec("jr",  OP_RTYPE, FN_JR, 1'b0);
   endtask

   task automatic test_illegal();
      exec("ill_op",    6'h3F,    6'h00, 1'b0);
      exec("ill_funct", OP_RTYPE, 6'h3F, 1'b0);
      exec("after_ill", OP_RTYPE, FN_OR, 1'b0);
   endtask

   task automatic test_reset_abort();
      rec_t e, g;
      @(posedge clk); #1;
      op = OP_LW; funct = 6'h00; zero = 1'b0;
      push_expect(OP_LW, 6'h00, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         e = q.pop_front();
         g = observed();
         checks++;
         if (g !== e) begin
            errors++; $display("FAIL abort_lw cycle%0d got %h exp %h", i, g, e);
         end
      end
      rst_n = 1'b0;
      #1;
      q.delete();
      exp_instret = '0;
      exp_illegal = 1'b0;
      g = observed();
      checks++;
      if (g !== blank(S_IDLE) || instret !== 32'd0 || illegal !== 1'b0) begin
         errors++; $display("FAIL abort_immediate got %h/%0d/%0b exp %h/0/0", g, instret, illegal, blank(S_IDLE));
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (RFWr !== 1'b0 || state !== S_IDLE) begin
            errors++; $display("FAIL abort_hold got rfwr=%0b state=%0d exp rfwr=0 state=0", RFWr, state);
         end
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (RFWr !== 1'b0 || state !== S_IDLE) begin
         errors++; $display("FAIL abort_release got rfwr=%0b state=%0d exp rfwr=0 state=0", RFWr, state);
      end
      exec("add_after_abort", OP_RTYPE, FN_ADD, 1'b0);
      exec("sw_after_abort",  OP_SW,    6'h00,  1'b0);
   endtask

   task automatic test_final();
      @(posedge clk); #1;
      checks++;
      if (instret !== exp_instret) begin
         errors++; $display("FAIL final_instret got %0d exp %0d", instret, exp_instret);
      end
      checks++;
      if (illegal !== exp_illegal) begin
         errors++; $display("FAIL final_illegal got %0b exp %0b", illegal, exp_illegal);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_itype();
      test_mem();
      test_branch();
      test_jump();
      test_illegal();
      test_reset_abort();
      test_final();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
